// File: rtl/instr_fetch_group.sv
// ---------------------------------------------------------------------------
// instr_fetch_group
//   Front-end fetch sequencer. Holds the fetch PC, issues 8-byte aligned
//   requests to the I-side memory port (credit-limited), buffers in-order
//   responses and presents each group as two 32-bit slots with per-halfword
//   valid bits plus the true entry PC of the group.
//
// Optional feature macro: IFETCH_FAULT_EN
//   defined   : o_fault port exists; a kept faulting beat halts fetch until
//               the next redirect.
//   undefined : i_resp_fault is ignored and fetch never halts.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_redirect     PC redirect / flush, highest priority after reset
//   i_redirect_pc  new fetch PC (2-byte aligned)
//   i_stall        hold the output group
//   o_req_valid    memory request valid
//   o_req_addr     8-byte aligned request address
//   i_req_ready    memory accepts the request
//   i_resp_valid   response beat (in request order)
//   i_resp_data    group bytes 0..7, little-endian
//   i_resp_fault   access fault for this beat
//   o_pc           entry PC of the presented group
//   o_instrs       two slots; slot k = o_instrs[34k +: 34] = {valid[1:0], instr[31:0]}
//                  valid[0] covers instr[15:0], valid[1] covers instr[31:16]
//   o_fault        group faulted (IFETCH_FAULT_EN only)
// ---------------------------------------------------------------------------
module instr_fetch_group #(
  parameter int                     VADDR_WIDTH     = 32,
  parameter logic [VADDR_WIDTH-1:0] RESET_PC        = 32'h8000_0000,
  parameter int                     MAX_OUTSTANDING = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_redirect,
  input  logic [VADDR_WIDTH-1:0] i_redirect_pc,
  input  logic                   i_stall,
  output logic                   o_req_valid,
  output logic [VADDR_WIDTH-1:0] o_req_addr,
  input  logic                   i_req_ready,
  input  logic                   i_resp_valid,
  input  logic [63:0]            i_resp_data,
  input  logic                   i_resp_fault,
  output logic [VADDR_WIDTH-1:0] o_pc,
  output logic [67:0]            o_instrs
`ifdef IFETCH_FAULT_EN
  ,
  output logic                   o_fault
`endif
);

  // FIFO entry layout: {fault, entry pc, data}
  localparam int                     ENTRY_W     = 1 + VADDR_WIDTH + 64;
  localparam logic [2:0]             MAX_CREDITS = 3'(MAX_OUTSTANDING);
  localparam logic [VADDR_WIDTH-4:0] GROUP_INC   = {{(VADDR_WIDTH-4){1'b0}}, 1'b1};

  // Per-halfword valid bits from the entry offset pc[2:1]
  function automatic logic [3:0] hw_valid(input logic [1:0] off);
    logic [3:0] v;
    case (off)
      2'd0:    v = 4'b1111;
      2'd1:    v = 4'b1110;
      2'd2:    v = 4'b1100;
      2'd3:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  logic                   r_run;
  logic [VADDR_WIDTH-1:0] r_fpc;
  logic [1:0]             r_outstanding;
  logic [1:0]             r_drop;
  // Queues are sized for the widest legal credit limit; the credit rule
  // bounds their occupancy to MAX_OUTSTANDING.
  logic [VADDR_WIDTH-1:0] r_tag_q [0:3];
  logic [1:0]             r_tag_wr;
  logic [1:0]             r_tag_rd;
  logic [ENTRY_W-1:0]     r_fifo [0:3];
  logic [1:0]             r_fifo_wr;
  logic [1:0]             r_fifo_rd;
  logic [1:0]             r_fifo_cnt;
  logic [63:0]            r_out_data;
  logic [3:0]             r_out_vld;
  logic [VADDR_WIDTH-1:0] r_out_pc;
  logic                   r_out_fault;

  logic                   w_halted;
  logic                   w_fault_in;
  logic                   w_beat_keep;
  logic                   w_fifo_empty;
  logic                   w_pop;
  logic                   w_bypass;
  logic                   w_push;
  logic                   w_credit;
  logic                   w_accept;
  logic                   w_avail;
  logic [ENTRY_W-1:0]     w_beat;
  logic [ENTRY_W-1:0]     w_next;
  logic [VADDR_WIDTH-1:0] w_next_pc;

`ifdef IFETCH_FAULT_EN
  logic r_halted;
  assign w_fault_in = i_resp_fault;
  assign w_halted   = r_halted;
  assign o_fault    = r_out_fault;

  // Halt after a kept faulting beat; only a redirect restarts fetch
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_halted <= 1'b0;
    end else if (i_redirect) begin
      r_halted <= 1'b0;
    end else if (w_beat_keep && i_resp_fault) begin
      r_halted <= 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_fault_in = 1'b0;
  assign w_halted   = 1'b0;
  assign w_unused   = &{1'b0, i_resp_fault, r_out_fault};
`endif

  // Beats still owed to a pre-redirect request are discarded
  assign w_beat_keep  = i_resp_valid & (r_drop == 2'd0);
  assign w_beat       = {w_fault_in, r_tag_q[r_tag_rd], i_resp_data};
  assign w_fifo_empty = (r_fifo_cnt == 2'd0);
  assign w_pop        = ~i_redirect & ~i_stall & ~w_fifo_empty;
  assign w_bypass     = ~i_redirect & ~i_stall & w_fifo_empty & w_beat_keep;
  assign w_push       = ~i_redirect & w_beat_keep & ~w_bypass;
  assign w_next       = w_fifo_empty ? w_beat : r_fifo[r_fifo_rd];
  assign w_next_pc    = w_next[64 +: VADDR_WIDTH];
  assign w_avail      = ~w_fifo_empty | w_beat_keep;

  // Credits cover requests in flight plus beats parked in the FIFO
  assign w_credit    = ({1'b0, r_outstanding} + {1'b0, r_fifo_cnt}) < MAX_CREDITS;
  assign o_req_valid = i_rst_n & r_run & ~w_halted & ~i_redirect & w_credit;
  assign w_accept    = o_req_valid & i_req_ready;
  assign o_req_addr  = {r_fpc[VADDR_WIDTH-1:3], 3'b000};

  assign o_pc     = r_out_pc;
  assign o_instrs = {r_out_vld[3:2], r_out_data[63:32], r_out_vld[1:0], r_out_data[31:0]};

  // Fetch PC, in-flight and drop counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_run         <= 1'b0;
      r_fpc         <= RESET_PC;
      r_outstanding <= 2'd0;
      r_drop        <= 2'd0;
    end else begin
      r_run         <= 1'b1;
      r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, i_resp_valid};
      if (i_redirect) begin
        r_fpc  <= i_redirect_pc;
        // every request still in flight after this edge is stale
        r_drop <= r_outstanding - {1'b0, i_resp_valid};
      end else begin
        if (w_accept) begin
          r_fpc <= {r_fpc[VADDR_WIDTH-1:3] + GROUP_INC, 3'b000};
        end
        if (i_resp_valid && (r_drop != 2'd0)) begin
          r_drop <= r_drop - 2'd1;
        end
      end
    end
  end

  // Entry-PC tag queue; every beat, kept or dropped, retires one tag
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tag_wr <= 2'd0;
      r_tag_rd <= 2'd0;
    end else begin
      if (w_accept) begin
        r_tag_q[r_tag_wr] <= r_fpc;
        r_tag_wr          <= r_tag_wr + 2'd1;
      end
      if (i_resp_valid) begin
        r_tag_rd <= r_tag_rd + 2'd1;
      end
    end
  end

  // Response FIFO and output group register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fifo_wr   <= 2'd0;
      r_fifo_rd   <= 2'd0;
      r_fifo_cnt  <= 2'd0;
      r_out_data  <= 64'd0;
      r_out_vld   <= 4'b0000;
      r_out_pc    <= {VADDR_WIDTH{1'b0}};
      r_out_fault <= 1'b0;
    end else if (i_redirect) begin
      r_fifo_wr   <= 2'd0;
      r_fifo_rd   <= 2'd0;
      r_fifo_cnt  <= 2'd0;
      r_out_vld   <= 4'b0000;
      r_out_fault <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_fifo_wr] <= w_beat;
        r_fifo_wr         <= r_fifo_wr + 2'd1;
      end
      if (w_pop) begin
        r_fifo_rd <= r_fifo_rd + 2'd1;
      end
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (!i_stall) begin
        if (w_avail) begin
          r_out_data  <= w_next[63:0];
          r_out_pc    <= w_next_pc;
          r_out_vld   <= hw_valid(w_next_pc[2:1]);
          r_out_fault <= w_next[ENTRY_W-1];
        end else begin
          r_out_vld   <= 4'b0000;
          r_out_fault <= 1'b0;
        end
      end
    end
  end

  instr_fetch_group_chk #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_chk (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_outstanding (r_outstanding),
    .i_drop        (r_drop),
    .i_fifo_cnt    (r_fifo_cnt),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_resp_valid  (i_resp_valid)
  );

endmodule

// ---------------------------------------------------------------------------
// instr_fetch_group_chk
//   Invariants of the fetch sequencer counters and response FIFO.
// Ports: clock/reset, counter values, FIFO push/pop strobes, response valid.
// ---------------------------------------------------------------------------
module instr_fetch_group_chk #(
  parameter int MAX_OUTSTANDING = 2
) (
  input logic       i_clk,
  input logic       i_rst_n,
  input logic [1:0] i_outstanding,
  input logic [1:0] i_drop,
  input logic [1:0] i_fifo_cnt,
  input logic       i_push,
  input logic       i_pop,
  input logic       i_resp_valid
);
  localparam logic [2:0] MAX_CREDITS = 3'(MAX_OUTSTANDING);

  a_out_max: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    {1'b0, i_outstanding} <= MAX_CREDITS);
  a_credit_sum: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ({1'b0, i_outstanding} + {1'b0, i_fifo_cnt}) <= MAX_CREDITS);
  a_drop_le_out: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_drop <= i_outstanding);
  a_fifo_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && ({1'b0, i_fifo_cnt} == MAX_CREDITS)));
  a_resp_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_resp_valid && (i_outstanding == 2'd0)));
endmodule
